// File: rtl/four_to_two_encoder.sv
`default_nettype none
// ============================================================================
// Module      : four_to_two_encoder
// Description : Registered 4-to-2 encoder with request queuing. Request
//               strobes are collected as pending bits and served one binary
//               index at a time over a valid/ready handshake. The selection
//               policy is fixed-priority (highest index) or round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module four_to_two_encoder #(
  parameter int ROUND_ROBIN = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in,
  output logic [1:0] out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] pending,
  output logic       overrun
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [1:0] last;
  logic [1:0] last_next;
  logic [1:0] sel;
  logic [1:0] out_next;
  logic [3:0] sel_onehot;
  logic [3:0] pending_next;
  logic       load;
  logic       overrun_next;

  // Selection looks only at the registered pending set, never at this cycle's strobes.
  generate
    if (ROUND_ROBIN != 0) begin : g_round_robin
      // Scan from last+1 upward; scanning in reverse lets the first hit overwrite later ones.
      always_comb begin
        sel = last;
        for (int k = 4; k >= 1; k--) begin
          if (pending[last + 2'(k)]) begin
            sel = last + 2'(k);
          end
        end
      end
    end else begin : g_fixed_priority
      // Highest set bit wins: later iterations override lower indices.
      always_comb begin
        sel = 2'b00;
        for (int i = 0; i < 4; i++) begin
          if (pending[i]) begin
            sel = 2'(i);
          end
        end
      end
    end
  endgenerate

  // Next-state, load decision, pending merge and overrun detection.
  always_comb begin
    state_next = state;
    out_next   = out;
    last_next  = last;
    sel_onehot = 4'b0000;
    load       = 1'b0;

    case (state)
      IDLE: begin
        if (|pending) begin
          load = 1'b1;
        end
      end
      PRESENT: begin
        if (out_ready) begin
          if (|pending) begin
            load = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (load) begin
      sel_onehot = 4'b0001 << sel;
      out_next   = sel;
      last_next  = sel;
      state_next = PRESENT;
    end

    // A strobe landing on the bit being served re-queues it (set wins).
    pending_next = (pending & ~sel_onehot) | in;
    overrun_next = |(in & pending & ~sel_onehot);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      out     <= 2'b00;
      last    <= 2'b11;
      pending <= 4'b0000;
      overrun <= 1'b0;
    end else begin
      state   <= state_next;
      out     <= out_next;
      last    <= last_next;
      pending <= pending_next;
      overrun <= overrun_next;
    end
  end

  assign out_valid = (state == PRESENT);

endmodule
`default_nettype wire

// File: doc/four_to_two_encoder.md
# four_to_two_encoder

Registered 4-to-2 encoder with request queuing: the inverse of the 2-to-4 decoder in the same design. It collects one-hot or multi-hot request strobes on a 4-bit input and holds them as pending bits. It emits one 2-bit index per request on a valid/ready output handshake, clearing each pending bit as it is served. It sits between decoded request sources and a single downstream consumer of binary indices.

## Interface
- ROUND_ROBIN, default 0: 0 = fixed priority, highest index wins; 1 = round-robin search starting one index above the last served.
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in  input  4  request strobes; bit i high for a cycle requests index i; any number of bits may be high at once.
- out  output  2  encoded index of the request being presented.
- out_valid  output  1  out holds a valid index.
- out_ready  input  1  consumer accepts out on a cycle with out_valid && out_ready (handshake).
- pending  output  4  registered set of requests not yet loaded into out.
- overrun  output  1  one-cycle pulse: a request arrived for an index already pending.

## Operation
- Reset (rst high at an edge): pending=0000, out=00, out_valid=0, overrun=0, round-robin pointer last=3. Reset overrides all other activity, including a request or handshake in progress; queued requests are discarded.
- States: IDLE (out_valid=0) and PRESENT (out_valid=1).
- Selection reads the pending register as it stands before the edge. It does not use the in bits of the same cycle.
  - Fixed priority: highest set bit.
  - Round-robin: first set bit scanning last+1, last+2, … mod 4.
- Pending update each edge: pending_next = (pending & ~sel_onehot) | in.
  - sel_onehot is the bit loaded into out this edge (0000 if no load).
  - Set wins: if in[i] is high on the edge that loads index i, pending[i] stays 1 and index i is queued again.
- IDLE: if pending != 0, load out=sel, set out_valid=1, update last=sel, go to PRESENT. Otherwise stay.
- PRESENT, no handshake: out, out_valid and last hold unchanged. No selection or clearing occurs, and pending only gains in bits.
- PRESENT, handshake:
  - If pending != 0, load the next sel in the same edge (back-to-back, out_valid stays 1).
  - Otherwise out_valid=0 and go to IDLE. out keeps its last value.
- Overrun: overrun_next = |(in & pending & ~sel_onehot). The request is merged, so one service covers both. Otherwise overrun_next=0.
- Width rules: out is a 2-bit binary index 0..3. The round-robin pointer wraps 3→0.

## Timing
- Latency: in[i] high before edge N sets pending[i] at N. out_valid/out are valid after edge N+1 if the block was IDLE. The minimum is 2 edges from strobe to presented index.
- Throughput: one index per cycle while out_ready=1 and pending is non-empty.
- out is stable from when out_valid rises until the handshake edge.
- overrun asserts for exactly the cycle after the offending edge.
- Simultaneous strobe for multiple indices: all are queued. They are served in priority order, one per handshake.

## Test plan
- Reset mid-PRESENT:
  - Stimulus: in=0110, hold out_ready=0 until out_valid=1, assert rst for 1 cycle.
  - Required: pending=0000, out_valid=0, out=00, overrun=0 next cycle; no output after rst drops.
- Single strobes with out_ready=1:
  - Stimulus: in=0001, 0010, 0100, 1000 each for one cycle, spaced 3 cycles apart.
  - Required: out=00, 01, 10, 11, each with out_valid high for exactly one cycle, 2 edges after its strobe.
- Fixed priority (ROUND_ROBIN=0):
  - Stimulus: in=1011 for one cycle, out_ready=1.
  - Required: out=11, 01, 00 on three consecutive cycles, then out_valid=0.
- Round robin (ROUND_ROBIN=1):
  - Stimulus: in=1111 once, then in=0001 on the cycle out=00 is presented.
  - Required: out sequence 00, 01, 10, 11, 00; pending ends 0000.
- Backpressure:
  - Stimulus: in=0100, hold out_ready=0 for 5 cycles, then release.
  - Required: out=10 stable with out_valid=1 throughout; a single handshake; then IDLE.
- Overrun and set-wins:
  - Stimulus: with out_ready=0 and pending[2]=1, pulse in=0100.
  - Required: overrun=1 for one cycle; after release, only one out=10 is presented.
  - Stimulus: pulse in[2] on the load edge of index 2.
  - Required: overrun=0; index 2 is presented a second time.
